fft8_seq_ctrl: RTL and testbench

//  Sequencer for an 8-point radix-2 DIT FFT built around ONE shared butterfly unit.

---
 rtl/fft8_seq_ctrl_if.sv | 63 ++++++
 rtl/fft8_seq_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_fft8_seq_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft8_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft8_seq_ctrl_if
//  Purpose  : Bundles the sample input stream, the shared-butterfly issue /
//             result bus, the spectrum output stream and the status flags of
//             the 8-point FFT sequencer.
//  Ports    : master - the sequencer side (drives in_ready, bf_* operands,
//                      out_* stream, busy, done)
//             slave  - the environment side (sample source, butterfly unit,
//                      spectrum sink)
//  Revision : 1.0 - initial release
// ============================================================================
interface fft8_seq_ctrl_if #(
   parameter int DW = 8
);
   // sample input stream
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_re;
   logic [DW-1:0] in_im;
   // butterfly issue
   logic          bf_valid;
   logic [DW-1:0] bf_ar;
   logic [DW-1:0] bf_ai;
   logic [DW-1:0] bf_br;
   logic [DW-1:0] bf_bi;
   logic [1:0]    bf_tw;
   // butterfly results
   logic [DW-1:0] bf_xr;
   logic [DW-1:0] bf_xi;
   logic [DW-1:0] bf_yr;
   logic [DW-1:0] bf_yi;
   // spectrum output stream
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_re;
   logic [DW-1:0] out_im;
   logic [2:0]    out_idx;
   // status
   logic          busy;
   logic          done;

   modport master (
      input  in_valid, in_re, in_im,
      input  bf_xr, bf_xi, bf_yr, bf_yi,
      input  out_ready,
      output in_ready,
      output bf_valid, bf_ar, bf_ai, bf_br, bf_bi, bf_tw,
      output out_valid, out_re, out_im, out_idx,
      output busy, done
   );

   modport slave (
      output in_valid, in_re, in_im,
      output bf_xr, bf_xi, bf_yr, bf_yi,
      output out_ready,
      input  in_ready,
      input  bf_valid, bf_ar, bf_ai, bf_br, bf_bi, bf_tw,
      input  out_valid, out_re, out_im, out_idx,
      input  busy, done
   );
endinterface
`default_nettype wire

// File: rtl/fft8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fft8_seq_ctrl
//  Purpose  : Sequencer for an 8-point radix-2 DIT FFT around one shared,
//             external butterfly unit. Loads a frame in bit-reversed order,
//             issues 3 stages x 4 butterflies with in-place writeback, then
//             streams the spectrum out in natural order.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             bus    - fft8_seq_ctrl_if.master (sample in, butterfly issue /
//                      result, spectrum out, busy, done)
//  Params   : DW     - component width, two's complement
//             BF_LAT - butterfly latency in cycles, 0..4
//  Revision : 1.0 - initial release
// ============================================================================
module fft8_seq_ctrl #(
   parameter int DW     = 8,
   parameter int BF_LAT = 1
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   fft8_seq_ctrl_if.master  bus
);

   localparam int PW = (BF_LAT > 0) ? BF_LAT : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_UNLOAD = 3'd4
   } state_t;

   state_t        state_q;
   logic [2:0]    cnt_q;        // sample index while loading, bin index while unloading
   logic [1:0]    stage_q;
   logic [1:0]    bfly_q;
   logic          in_ready_q;
   logic          bf_valid_q;
   logic          out_valid_q;
   logic [DW-1:0] rf_re_q [8];
   logic [DW-1:0] rf_im_q [8];

   // writeback pipe: index 0 is the newest issue, PW-1 the one being written
   logic [PW-1:0] pv_q;
   logic [2:0]    pta_q [PW];
   logic [2:0]    pba_q [PW];

   logic [2:0]    w_ta;
   logic [2:0]    w_ba;
   logic [1:0]    w_tw;
   logic [2:0]    w_ld_addr;
   logic          w_wb_en;
   logic [2:0]    w_wb_ta;
   logic [2:0]    w_wb_ba;
   logic          w_pipe_last;

   // Butterfly addressing per stage; bottom address is top plus span 1<<s.
   always_comb begin
      w_ta = 3'd0;
      w_ba = 3'd0;
      w_tw = 2'd0;
      case (stage_q)
         2'd0: begin
            w_ta = {bfly_q, 1'b0};
            w_ba = {bfly_q, 1'b1};
            w_tw = 2'd0;
         end
         2'd1: begin
            w_ta = {bfly_q[1], 1'b0, bfly_q[0]};
            w_ba = {bfly_q[1], 1'b1, bfly_q[0]};
            w_tw = {bfly_q[0], 1'b0};
         end
         default: begin
            w_ta = {1'b0, bfly_q};
            w_ba = {1'b1, bfly_q};
            w_tw = bfly_q;
         end
      endcase
   end

   // arrival order n lands at bit-reversed entry
   assign w_ld_addr = {cnt_q[0], cnt_q[1], cnt_q[2]};

   generate
      if (BF_LAT == 0) begin : g_wb_direct
         // result is valid in the issue cycle itself
         assign w_wb_en     = bf_valid_q;
         assign w_wb_ta     = w_ta;
         assign w_wb_ba     = w_ba;
         assign w_pipe_last = 1'b1;
      end else begin : g_wb_pipe
         assign w_wb_en = pv_q[BF_LAT-1];
         assign w_wb_ta = pta_q[BF_LAT-1];
         assign w_wb_ba = pba_q[BF_LAT-1];
         // DRAIN may leave once only the oldest slot (written this edge) can be busy
         if (BF_LAT == 1) begin : g_one
            assign w_pipe_last = 1'b1;
         end else begin : g_multi
            assign w_pipe_last = (pv_q[BF_LAT-2:0] == '0);
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         stage_q     <= 2'd0;
         bfly_q      <= 2'd0;
         in_ready_q  <= 1'b1;
         bf_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         pv_q        <= '0;
         for (int i = 0; i < 8; i++) begin
            rf_re_q[i] <= '0;
            rf_im_q[i] <= '0;
         end
         for (int k = 0; k < PW; k++) begin
            pta_q[k] <= 3'd0;
            pba_q[k] <= 3'd0;
         end
      end else begin
         if (w_wb_en) begin
            rf_re_q[w_wb_ta] <= bus.bf_xr;
            rf_im_q[w_wb_ta] <= bus.bf_xi;
            rf_re_q[w_wb_ba] <= bus.bf_yr;
            rf_im_q[w_wb_ba] <= bus.bf_yi;
         end

         for (int k = PW - 1; k > 0; k--) begin
            pv_q[k]  <= pv_q[k-1];
            pta_q[k] <= pta_q[k-1];
            pba_q[k] <= pba_q[k-1];
         end
         pv_q[0]  <= bf_valid_q;
         pta_q[0] <= w_ta;
         pba_q[0] <= w_ba;

         case (state_q)
            ST_IDLE, ST_LOAD: begin
               if (bus.in_valid && in_ready_q) begin
                  rf_re_q[w_ld_addr] <= bus.in_re;
                  rf_im_q[w_ld_addr] <= bus.in_im;
                  if (cnt_q == 3'd7) begin
                     cnt_q      <= 3'd0;
                     state_q    <= ST_ISSUE;
                     in_ready_q <= 1'b0;
                     bf_valid_q <= 1'b1;
                     stage_q    <= 2'd0;
                     bfly_q     <= 2'd0;
                  end else begin
                     cnt_q   <= cnt_q + 3'd1;
                     state_q <= ST_LOAD;
                  end
               end
            end

            ST_ISSUE: begin
               bfly_q <= bfly_q + 2'd1;
               if (bfly_q == 2'd3) begin
                  if (BF_LAT == 0) begin
                     // nothing in flight: skip DRAIN entirely
                     if (stage_q == 2'd2) begin
                        state_q     <= ST_UNLOAD;
                        bf_valid_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        cnt_q       <= 3'd0;
                        stage_q     <= 2'd0;
                     end else begin
                        stage_q <= stage_q + 2'd1;
                     end
                  end else begin
                     state_q    <= ST_DRAIN;
                     bf_valid_q <= 1'b0;
                  end
               end
            end

            ST_DRAIN: begin
               if (w_pipe_last) begin
                  if (stage_q == 2'd2) begin
                     state_q     <= ST_UNLOAD;
                     out_valid_q <= 1'b1;
                     cnt_q       <= 3'd0;
                     stage_q     <= 2'd0;
                  end else begin
                     state_q    <= ST_ISSUE;
                     stage_q    <= stage_q + 2'd1;
                     bfly_q     <= 2'd0;
                     bf_valid_q <= 1'b1;
                  end
               end
            end

            ST_UNLOAD: begin
               if (bus.out_ready) begin
                  if (cnt_q == 3'd7) begin
                     state_q     <= ST_IDLE;
                     out_valid_q <= 1'b0;
                     in_ready_q  <= 1'b1;
                     cnt_q       <= 3'd0;
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Operand and bin buses read the register file directly so that a result
   // written on the edge that starts the next stage is already visible.
   assign bus.in_ready  = in_ready_q;
   assign bus.bf_valid  = bf_valid_q;
   assign bus.bf_ar     = bf_valid_q ? rf_re_q[w_ta] : '0;
   assign bus.bf_ai     = bf_valid_q ? rf_im_q[w_ta] : '0;
   assign bus.bf_br     = bf_valid_q ? rf_re_q[w_ba] : '0;
   assign bus.bf_bi     = bf_valid_q ? rf_im_q[w_ba] : '0;
   assign bus.bf_tw     = bf_valid_q ? w_tw : 2'd0;
   assign bus.out_valid = out_valid_q;
   assign bus.out_re    = out_valid_q ? rf_re_q[cnt_q] : '0;
   assign bus.out_im    = out_valid_q ? rf_im_q[cnt_q] : '0;
   assign bus.out_idx   = out_valid_q ? cnt_q : 3'd0;
   assign bus.busy      = (state_q != ST_IDLE);
   // coincides with the handshake of bin 7 so the next frame starts right after
   assign bus.done      = out_valid_q && bus.out_ready && (cnt_q == 3'd7);

endmodule
`default_nettype wire

// File: tb/tb_fft8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft8_seq_ctrl
//  Purpose  : Self-checking bench for fft8_seq_ctrl. Three instances with
//             butterfly latencies 0, 1 and 4 share the stimulus; detailed
//             checks run on the latency-1 instance, issue timing on all.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft8_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_re;
   logic [7:0] in_im;
   logic       out_ready;

   logic [2:0] bfv, ir, ov, bsy, dn;
   logic [7:0] o_ar [3];
   logic [7:0] o_ai [3];
   logic [7:0] o_br [3];
   logic [7:0] o_bi [3];
   logic [7:0] o_re [3];
   logic [7:0] o_im [3];
   logic [1:0] o_tw [3];
   logic [2:0] o_idx [3];

   int n_chk = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural butterfly: W8^k in Q8, result {xr, xi, yr, yi}, modulo 2^8
   function automatic logic [31:0] bfly(input logic [7:0] ar, input logic [7:0] ai,
                                        input logic [7:0] br, input logic [7:0] bi,
                                        input logic [1:0] k);
      int a_r, a_i, b_r, b_i, wr, wi, pr, pi, xr, xi, yr, yi;
      a_r = int'($signed(ar));
      a_i = int'($signed(ai));
      b_r = int'($signed(br));
      b_i = int'($signed(bi));
      case (k)
         2'd0:    begin wr = 256;  wi = 0;    end
         2'd1:    begin wr = 181;  wi = -181; end
         2'd2:    begin wr = 0;    wi = -256; end
         default: begin wr = -181; wi = -181; end
      endcase
      pr = (b_r * wr - b_i * wi) >>> 8;
      pi = (b_r * wi + b_i * wr) >>> 8;
      xr = a_r + pr;
      xi = a_i + pi;
      yr = a_r - pr;
      yi = a_i - pi;
      return {xr[7:0], xi[7:0], yr[7:0], yi[7:0]};
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 0 : ((gi == 1) ? 1 : 4);
      fft8_seq_ctrl_if #(.DW(8)) bus ();
      fft8_seq_ctrl #(.DW(8), .BF_LAT(LAT)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
      logic [31:0] res;
      assign bus.in_valid  = in_valid;
      assign bus.in_re     = in_re;
      assign bus.in_im     = in_im;
      assign bus.out_ready = out_ready;
      assign res = bfly(bus.bf_ar, bus.bf_ai, bus.bf_br, bus.bf_bi, bus.bf_tw);
      if (LAT == 0) begin : g_comb
         assign {bus.bf_xr, bus.bf_xi, bus.bf_yr, bus.bf_yi} = res;
      end else begin : g_pipe
         logic [31:0] dly [LAT];
         always @(posedge clk) begin
            dly[0] <= res;
            for (int k = 1; k < LAT; k++) dly[k] <= dly[k-1];
         end
         assign {bus.bf_xr, bus.bf_xi, bus.bf_yr, bus.bf_yi} = dly[LAT-1];
      end
      assign bfv[gi]   = bus.bf_valid;
      assign ir[gi]    = bus.in_ready;
      assign ov[gi]    = bus.out_valid;
      assign bsy[gi]   = bus.busy;
      assign dn[gi]    = bus.done;
      assign o_ar[gi]  = bus.bf_ar;
      assign o_ai[gi]  = bus.bf_ai;
      assign o_br[gi]  = bus.bf_br;
      assign o_bi[gi]  = bus.bf_bi;
      assign o_re[gi]  = bus.out_re;
      assign o_im[gi]  = bus.out_im;
      assign o_tw[gi]  = bus.bf_tw;
      assign o_idx[gi] = bus.out_idx;
   end

   // ---------------- tables ----------------
   typedef struct {
      logic [7:0] in_re;
      logic [7:0] in_im;
      logic       chk;
      logic [7:0] ex_re;
      logic [7:0] ex_im;
   } vec_t;
   vec_t vt [16];   // 0..7 impulse frame, 8..15 ramp frame

   typedef struct {
      logic [2:0] ta;
      logic [2:0] ba;
      logic [1:0] tw;
   } sch_t;
   sch_t sch [12];

   logic [7:0] mre [8];
   logic [7:0] mim [8];

   // ---------------- monitors ----------------
   int done_cnt = 0;
   int lp_pulse [3] = '{0, 0, 0};
   int lp_cyc   [3] = '{0, 0, 0};
   bit lp_start [3] = '{0, 0, 0};
   bit lp_done  [3] = '{0, 0, 0};

   always @(negedge clk) begin
      if (dn[1]) done_cnt++;
      for (int j = 0; j < 3; j++) begin
         if (rst_n && !lp_done[j]) begin
            if (ov[j]) lp_done[j] = 1'b1;
            else if (lp_start[j] || bfv[j]) begin
               lp_start[j] = 1'b1;
               lp_cyc[j]++;
               if (bfv[j]) lp_pulse[j]++;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send_frame(input int base);
      int t;
      for (int n = 0; n < 8; n++) begin
         in_valid = 1'b1;
         in_re    = vt[base+n].in_re;
         in_im    = vt[base+n].in_im;
         t = 0;
         while (!ir[1] && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (!ir[1]) chk($sformatf("load_timeout_n%0d", n), 0, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic compute(input int base, input bit hold, input bit chk_ops);
      int t, iss, viol;
      logic [31:0] r;
      logic [2:0] nn, ta, ba;
      for (int n = 0; n < 8; n++) begin
         nn = 3'(n);
         mre[{nn[0], nn[1], nn[2]}] = vt[base+n].in_re;
         mim[{nn[0], nn[1], nn[2]}] = vt[base+n].in_im;
      end
      if (hold) begin
         in_valid = 1'b1;
         in_re    = 8'h55;
         in_im    = 8'h55;
      end
      t = 0; iss = 0; viol = 0;
      while (!ov[1] && t < 100) begin
         if (ir[1]) viol++;
         if (bfv[1]) begin
            if (chk_ops && iss < 12) begin
               ta = sch[iss].ta;
               ba = sch[iss].ba;
               chk($sformatf("issue%0d_tw", iss), o_tw[1], sch[iss].tw);
               chk($sformatf("issue%0d_ar", iss), o_ar[1], mre[ta]);
               chk($sformatf("issue%0d_ai", iss), o_ai[1], mim[ta]);
               chk($sformatf("issue%0d_br", iss), o_br[1], mre[ba]);
               chk($sformatf("issue%0d_bi", iss), o_bi[1], mim[ba]);
               r = bfly(mre[ta], mim[ta], mre[ba], mim[ba], sch[iss].tw);
               mre[ta] = r[31:24];
               mim[ta] = r[23:16];
               mre[ba] = r[15:8];
               mim[ba] = r[7:0];
            end
            iss++;
         end
         @(negedge clk);
         t++;
      end
      in_valid = 1'b0;
      chk("compute_reaches_unload", ov[1], 1);
      chk("issue_count", iss, 12);
      chk("in_ready_during_compute", viol, 0);
   endtask

   task automatic recv(input int base, input bit bp);
      int t, d0;
      d0 = done_cnt;
      out_ready = 1'b1;
      for (int m = 0; m < 8; m++) begin
         t = 0;
         while (!ov[1] && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk($sformatf("bin%0d_out_valid", m), ov[1], 1);
         if (bp && m == 2) begin
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("stall_idx", o_idx[1], 2);
               chk("stall_re", o_re[1], vt[base+2].ex_re);
               chk("stall_im", o_im[1], vt[base+2].ex_im);
            end
            out_ready = 1'b1;
         end
         chk($sformatf("bin%0d_idx", m), o_idx[1], m);
         if (vt[base+m].chk) begin
            chk($sformatf("bin%0d_re", m), o_re[1], vt[base+m].ex_re);
            chk($sformatf("bin%0d_im", m), o_im[1], vt[base+m].ex_im);
         end
         chk($sformatf("bin%0d_done", m), dn[1], (m == 7) ? 1 : 0);
         @(negedge clk);
      end
      chk("done_pulses", done_cnt - d0, 1);
      chk("in_ready_after_done", ir[1], 1);
      chk("out_valid_after_done", ov[1], 0);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (bsy != 3'b000 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("all_idle", bsy, 0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"},  ir[1], 1);
      chk({tag, "_bf_valid"},  bfv[1], 0);
      chk({tag, "_out_valid"}, ov[1], 0);
      chk({tag, "_busy"},      bsy[1], 0);
      chk({tag, "_done"},      dn[1], 0);
      chk({tag, "_bf_ar"},     o_ar[1], 0);
      chk({tag, "_bf_br"},     o_br[1], 0);
      chk({tag, "_bf_tw"},     o_tw[1], 0);
      chk({tag, "_out_re"},    o_re[1], 0);
      chk({tag, "_out_idx"},   o_idx[1], 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int p, t;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_re     = 8'd0;
      in_im     = 8'd0;
      out_ready = 1'b1;

      for (int n = 0; n < 8; n++) begin
         vt[n].in_re   = (n == 0) ? 8'd1 : 8'd0;
         vt[n].in_im   = 8'd0;
         vt[n].chk     = 1'b1;
         vt[n].ex_re   = 8'd1;
         vt[n].ex_im   = 8'd0;
         vt[8+n].in_re = 8'(n);
         vt[8+n].in_im = 8'd0;
         vt[8+n].chk   = (n % 2 == 0);
         vt[8+n].ex_re = 8'd0;
         vt[8+n].ex_im = 8'd0;
      end
      // ramp spectrum, even bins: X0=28, X2=-4+4j, X4=-4, X6=-4-4j
      vt[8].ex_re  = 8'd28;  vt[8].ex_im  = 8'd0;
      vt[10].ex_re = 8'hFC;  vt[10].ex_im = 8'h04;
      vt[12].ex_re = 8'hFC;  vt[12].ex_im = 8'h00;
      vt[14].ex_re = 8'hFC;  vt[14].ex_im = 8'hFC;

      sch[0]  = '{3'd0, 3'd1, 2'd0};
      sch[1]  = '{3'd2, 3'd3, 2'd0};
      sch[2]  = '{3'd4, 3'd5, 2'd0};
      sch[3]  = '{3'd6, 3'd7, 2'd0};
      sch[4]  = '{3'd0, 3'd2, 2'd0};
      sch[5]  = '{3'd1, 3'd3, 2'd2};
      sch[6]  = '{3'd4, 3'd6, 2'd0};
      sch[7]  = '{3'd5, 3'd7, 2'd2};
      sch[8]  = '{3'd0, 3'd4, 2'd0};
      sch[9]  = '{3'd1, 3'd5, 2'd1};
      sch[10] = '{3'd2, 3'd6, 2'd2};
      sch[11] = '{3'd3, 3'd7, 2'd3};

      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // impulse frame, in_valid held high through compute
      send_frame(0);
      compute(0, 1'b1, 1'b0);
      recv(0, 1'b0);
      wait_idle();
      chk("lat0_pulses", lp_pulse[0], 12);
      chk("lat0_cycles", lp_cyc[0], 12);
      chk("lat1_cycles", lp_cyc[1], 15);
      chk("lat4_pulses", lp_pulse[2], 12);
      chk("lat4_cycles", lp_cyc[2], 24);

      // ramp frame: addressing, operands, spectrum, backpressure at bin 2
      send_frame(8);
      compute(8, 1'b0, 1'b1);
      recv(8, 1'b1);
      wait_idle();

      // reset during the first stage-1 issue
      send_frame(0);
      p = 0; t = 0;
      while (p < 5 && t < 100) begin
         if (bfv[1]) p++;
         if (p < 5) begin
            @(negedge clk);
            t++;
         end
      end
      chk("midreset_reached_stage1", p, 5);
      chk("midreset_stage1_tw", o_tw[1], 0);
      rst_n = 1'b0;
      #1;
      chk_reset_state("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(0);
      compute(0, 1'b0, 1'b0);
      recv(0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
